frog_controller: RTL and testbench
==================================

Name: frog_controller

Overview:
- Player-input and game-state stage directly upstream of the VGA pixel writer.
- Debounces the five board switches and moves the frog one grid cell per video frame.
- Tracks collisions reported by the renderer and runs the game state machine (lives, score).
- Publishes frog position and game status that the pixel writer uses to draw the frog and HUD each frame.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before a button level is accepted (set to 1_000_000 for synthesis).
- STEP_X, 32, horizontal move distance in pixels.
- STEP_Y, 40, vertical move distance in pixels.
- START_X, 304, frog x after spawn.
- START_Y, 440, frog y after spawn.
- HOME_Y, 40, y at which a crossing is scored.
- MAX_X, 608, largest legal frog_x (640 minus 32-pixel frog width).
- DEATH_FRAMES, 60, frames spent in DYING.

Ports:
- clk  in  1  system clock, same domain as frame_tick.
- rst  in  1  synchronous active-high reset.
- sw1  in  1  up button, asynchronous raw level.
- sw2  in  1  down button, asynchronous raw level.
- sw3  in  1  left button, asynchronous raw level.
- sw4  in  1  right button, asynchronous raw level.
- sw5  in  1  start button, asynchronous raw level.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- car_hit  in  1  renderer flag: frog pixel overlapped a car pixel this cycle.
- frog_x  out  10  frog left edge.
- frog_y  out  9  frog top edge.
- lives  out  2  remaining lives.
- score  out  8  completed crossings, saturating.
- game_state  out  2  0 IDLE, 1 PLAY, 2 DYING, 3 OVER.

Behaviour:
- Reset values: frog_x=START_X, frog_y=START_Y, lives=3, score=0, game_state=IDLE. Debouncers cleared to 0; pending moves, hit flag and frame counter cleared. Reset has priority over every other event on the same cycle.
- Input path: each switch passes a 2-flop synchroniser, then a debouncer.
  - Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
  - A debounced 0->1 transition produces a one-cycle press pulse.
- Move requests: press pulses of sw1–sw4 set sticky pending bits.
  - Pending bits are consumed only on frame_tick, and are cleared on every frame_tick regardless of state.
  - At most one move per frame; priority up > down > left > right. Lower-priority pendings are discarded, not carried over.
  - A press pulse coincident with frame_tick is serviced on the next frame_tick.
- Move arithmetic, applied in the cycle after frame_tick (registered outputs):
  - up: frog_y -= STEP_Y.
  - down: frog_y += STEP_Y, ignored if result > START_Y.
  - left: ignored if frog_x < STEP_X.
  - right: ignored if frog_x + STEP_X > MAX_X, computed 11 bits wide.
  - No wrap-around is ever produced.
- Hit flag: set by car_hit while state is PLAY; cleared on every frame_tick. It is evaluated on frame_tick before any move.
- IDLE:
  - A sw5 press sets lives=3, score=0, frog to start, then enters PLAY.
  - Movement is ignored.
- PLAY, on frame_tick:
  - If the hit flag is set: lives -= 1, frame counter = 0, enter DYING. The pending move is discarded.
  - Otherwise apply the move. If the resulting frog_y == HOME_Y: score += 1 (holds at 255), frog respawns at start on the same update.
- DYING:
  - Frog position frozen; car_hit and moves ignored.
  - The frame counter increments on each frame_tick.
  - When it reaches DEATH_FRAMES-1 on a frame_tick: go to OVER if lives==0, else respawn the frog and go to PLAY.
- OVER:
  - Outputs hold.
  - A sw5 press returns to IDLE with the frog at start; score is retained until the next start.
- A sw5 press during PLAY or DYING is ignored.

Test Plan:
1. Reset, then check outputs → frog_x=304, frog_y=440, lives=3, score=0, game_state=0. A sw5 bounce of 5 cycles high/5 cycles low produces no press; sw5 held 20 cycles → game_state=1 within DEBOUNCE_CYCLES+3 cycles.
2. In PLAY, press sw1 and sw4 before one frame_tick → only the up move applies: frog_y=400, frog_x=304. Next frame_tick with no press → no change.
3. Press sw3 ten times, one per frame → frog_x = 272, 240, …, 16, then stays 16 (the 10th press is ignored). Press sw2 at spawn → frog_y stays 440.
4. Ten up moves from y=440 → on the 10th frame_tick score=1 and the frog is back at (304,440). Force score to 255 and complete a crossing → score stays 255.
5. Pulse car_hit for one cycle mid-frame with sw1 pending → next frame_tick gives lives=2, game_state=2, no move. After 60 frame_ticks → game_state=1 and frog at start.
6. Cause three hits → game_state=3 after the third DYING with lives=0. A sw5 press → game_state=0. Assert rst mid-DYING → all reset values on the next cycle.

Source files
------------

// File: rtl/frog_controller.sv
// Frog player controller: switch synchronise/debounce, once-per-frame movement,
// and the IDLE/PLAY/DYING/OVER game state machine driving the pixel writer.
module frog_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_X          = 32,
  parameter int unsigned STEP_Y          = 40,
  parameter int unsigned START_X         = 304,
  parameter int unsigned START_Y         = 440,
  parameter int unsigned HOME_Y          = 40,
  parameter int unsigned MAX_X           = 608,
  parameter int unsigned DEATH_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       sw4,
  input  logic       sw5,
  input  logic       frame_tick,
  input  logic       car_hit,
  output logic [9:0] frog_x,
  output logic [8:0] frog_y,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [1:0] game_state
);

  localparam int unsigned NSW    = 5;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FCNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  logic [NSW-1:0]   sw_raw;
  logic [NSW-1:0]   sync1_q, sync2_q;
  logic [NSW-1:0]   db_q, db_d;
  logic [NSW-1:0]   press_q, press_d;
  logic [CNT_W-1:0] db_cnt_q [NSW];
  logic [CNT_W-1:0] db_cnt_d [NSW];

  state_e            state_q, state_d;
  logic [9:0]        frog_x_q, frog_x_d;
  logic [8:0]        frog_y_q, frog_y_d;
  logic [1:0]        lives_q, lives_d;
  logic [7:0]        score_q, score_d;
  logic [3:0]        pend_q, pend_d;
  logic              hit_q, hit_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [9:0]        mv_x;
  logic [8:0]        mv_y;

  assign sw_raw = {sw5, sw4, sw3, sw2, sw1};

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NSW; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
    press_d = db_d & ~db_q;
  end

  // Candidate move from the highest-priority pending request; illegal moves leave the frog put.
  always_comb begin
    mv_x = frog_x_q;
    mv_y = frog_y_q;
    if (pend_q[0]) begin
      if (frog_y_q >= 9'(STEP_Y)) mv_y = frog_y_q - 9'(STEP_Y);
    end else if (pend_q[1]) begin
      if ({1'b0, frog_y_q} + 10'(STEP_Y) <= 10'(START_Y)) mv_y = frog_y_q + 9'(STEP_Y);
    end else if (pend_q[2]) begin
      if (frog_x_q >= 10'(STEP_X)) mv_x = frog_x_q - 10'(STEP_X);
    end else if (pend_q[3]) begin
      if ({1'b0, frog_x_q} + 11'(STEP_X) <= 11'(MAX_X)) mv_x = frog_x_q + 10'(STEP_X);
    end
  end

  always_comb begin
    state_d  = state_q;
    frog_x_d = frog_x_q;
    frog_y_d = frog_y_q;
    lives_d  = lives_q;
    score_d  = score_q;
    fcnt_d   = fcnt_q;
    pend_d   = frame_tick ? press_q[3:0] : (pend_q | press_q[3:0]);
    hit_d    = frame_tick ? 1'b0 : (hit_q | (car_hit && state_q == S_PLAY));
    unique case (state_q)
      S_IDLE: begin
        if (press_q[4]) begin
          lives_d  = 2'd3;
          score_d  = '0;
          frog_x_d = 10'(START_X);
          frog_y_d = 9'(START_Y);
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (hit_q || car_hit) begin
            lives_d = lives_q - 2'd1;
            fcnt_d  = '0;
            state_d = S_DYING;
          end else if (mv_y == 9'(HOME_Y)) begin
            if (score_q != 8'hff) score_d = score_q + 8'd1;
            frog_x_d = 10'(START_X);
            frog_y_d = 9'(START_Y);
          end else begin
            frog_x_d = mv_x;
            frog_y_d = mv_y;
          end
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (fcnt_q == FCNT_W'(DEATH_FRAMES - 1)) begin
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              frog_x_d = 10'(START_X);
              frog_y_d = 9'(START_Y);
              state_d  = S_PLAY;
            end
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end
      S_OVER: begin
        if (press_q[4]) begin
          frog_x_d = 10'(START_X);
          frog_y_d = 9'(START_Y);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      press_q  <= '0;
      for (int i = 0; i < NSW; i++) db_cnt_q[i] <= '0;
      state_q  <= S_IDLE;
      frog_x_q <= 10'(START_X);
      frog_y_q <= 9'(START_Y);
      lives_q  <= 2'd3;
      score_q  <= '0;
      pend_q   <= '0;
      hit_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      sync1_q  <= sw_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      press_q  <= press_d;
      for (int i = 0; i < NSW; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q  <= state_d;
      frog_x_q <= frog_x_d;
      frog_y_q <= frog_y_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      pend_q   <= pend_d;
      hit_q    <= hit_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign frog_x     = frog_x_q;
  assign frog_y     = frog_y_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_frog_controller.sv
// Bench for frog_controller: directed game scenarios plus random play, checked
// against an event-level game model (button presses and frames, not cycles).
module tb_frog_controller;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0, sw5 = 1'b0;
  logic       frame_tick = 1'b0;
  logic       car_hit = 1'b0;
  logic [9:0] frog_x;
  logic [8:0] frog_y;
  logic [1:0] lives;
  logic [7:0] score;
  logic [1:0] game_state;

  int checks = 0;
  int failures = 0;

  // Game model: 0 IDLE, 1 PLAY, 2 DYING, 3 OVER
  int m_x, m_y, m_lives, m_score, m_state, m_dying_frames;
  bit m_pend [4];
  bit m_hit;

  frog_controller dut (
    .clk(clk), .rst(rst),
    .sw1(sw1), .sw2(sw2), .sw3(sw3), .sw4(sw4), .sw5(sw5),
    .frame_tick(frame_tick), .car_hit(car_hit),
    .frog_x(frog_x), .frog_y(frog_y), .lives(lives), .score(score),
    .game_state(game_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".x"}, int'(frog_x), m_x);
    chk({tag, ".y"}, int'(frog_y), m_y);
    chk({tag, ".lives"}, int'(lives), m_lives);
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".state"}, int'(game_state), m_state);
  endtask

  task automatic model_reset();
    m_x = 304; m_y = 440; m_lives = 3; m_score = 0; m_state = 0;
    m_dying_frames = 0; m_hit = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
  endtask

  task automatic model_start();
    if (m_state == 0) begin
      m_lives = 3; m_score = 0; m_x = 304; m_y = 440; m_state = 1;
    end else if (m_state == 3) begin
      m_x = 304; m_y = 440; m_state = 0;
    end
  endtask

  task automatic model_tick();
    int nx, ny;
    if (m_state == 1) begin
      if (m_hit) begin
        m_lives--; m_dying_frames = 0; m_state = 2;
      end else begin
        nx = m_x; ny = m_y;
        if (m_pend[0]) begin
          if (m_y - 40 >= 0) ny = m_y - 40;
        end else if (m_pend[1]) begin
          if (m_y + 40 <= 440) ny = m_y + 40;
        end else if (m_pend[2]) begin
          if (m_x >= 32) nx = m_x - 32;
        end else if (m_pend[3]) begin
          if (m_x + 32 <= 608) nx = m_x + 32;
        end
        if (ny == 40) begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_x = 304; m_y = 440;
        end else begin
          m_x = nx; m_y = ny;
        end
      end
    end else if (m_state == 2) begin
      m_dying_frames++;
      if (m_dying_frames == 60) begin
        if (m_lives == 0) m_state = 3;
        else begin m_x = 304; m_y = 440; m_state = 1; end
      end
    end
    m_hit = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
  endtask

  // Full press: hold long enough to debounce, then release long enough to debounce back.
  task automatic press(input int btn);
    @(negedge clk);
    case (btn)
      0: sw1 = 1'b1; 1: sw2 = 1'b1; 2: sw3 = 1'b1; 3: sw4 = 1'b1; default: sw5 = 1'b1;
    endcase
    repeat (DEB + 6) @(negedge clk);
    {sw1, sw2, sw3, sw4, sw5} = '0;
    repeat (DEB + 6) @(negedge clk);
    if (btn < 4) m_pend[btn] = 1;
    else model_start();
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick();
  endtask

  task automatic hit_pulse();
    @(negedge clk);
    car_hit = 1'b1;
    @(negedge clk);
    car_hit = 1'b0;
    if (m_state == 1) m_hit = 1;
  endtask

  initial begin
    bit found;
    // 1: reset, bounce rejection, start latency
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst.x", int'(frog_x), 304);
    chk("rst.y", int'(frog_y), 440);
    chk("rst.lives", int'(lives), 3);
    chk("rst.score", int'(score), 0);
    chk("rst.state", int'(game_state), 0);
    for (int r = 0; r < 4; r++) begin
      sw5 = 1'b1; repeat (5) @(negedge clk);
      sw5 = 1'b0; repeat (5) @(negedge clk);
    end
    repeat (DEB + 6) @(negedge clk);
    chk("bounce.state", int'(game_state), 0);
    sw5 = 1'b1;
    found = 0;
    for (int i = 0; i < DEB + 3 && !found; i++) begin
      @(negedge clk);
      if (game_state == 2'd1) found = 1;
    end
    chk("start_latency", int'(found), 1);
    repeat (2) @(negedge clk);
    sw5 = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    model_start();
    chk_all("start");

    // 2: up beats right; idle frame changes nothing
    press(0); press(3); tick();
    chk("prio.y", int'(frog_y), 400);
    chk("prio.x", int'(frog_x), 304);
    chk_all("prio");
    tick();
    chk_all("noop");

    // 3: left to the edge, down blocked at spawn row
    for (int i = 0; i < 10; i++) begin
      press(2); tick();
      chk_all("left");
    end
    chk("left_edge.x", int'(frog_x), 16);
    press(1); tick();
    chk("down.y", int'(frog_y), 440);
    press(1); tick();
    chk("down_block.y", int'(frog_y), 440);

    // 4: crossing scores and respawns; score saturates
    for (int i = 0; i < 10; i++) begin
      press(0); tick();
      chk_all("cross");
    end
    chk("cross.score", int'(score), 1);
    chk("cross.x", int'(frog_x), 304);
    chk("cross.y", int'(frog_y), 440);
    @(negedge clk);
    force dut.score_q = 8'd255;
    @(negedge clk);
    release dut.score_q;
    m_score = 255;
    for (int i = 0; i < 10; i++) begin press(0); tick(); end
    chk("sat.score", int'(score), 255);
    chk_all("sat");

    // 5: hit with pending move, then 60 death frames
    press(0); hit_pulse(); tick();
    chk("hit.lives", int'(lives), 2);
    chk("hit.state", int'(game_state), 2);
    chk("hit.y", int'(frog_y), 440);
    for (int i = 0; i < 59; i++) tick();
    chk("dying59.state", int'(game_state), 2);
    tick();
    chk("respawn.state", int'(game_state), 1);
    chk_all("respawn");

    // 6: run out of lives, restart, reset mid-DYING
    for (int h = 0; h < 2; h++) begin
      hit_pulse(); tick();
      for (int i = 0; i < 60; i++) tick();
    end
    chk("over.state", int'(game_state), 3);
    chk("over.lives", int'(lives), 0);
    press(4);
    chk("over_idle.state", int'(game_state), 0);
    chk_all("over_idle");
    press(4);
    hit_pulse(); tick();
    for (int i = 0; i < 5; i++) tick();
    chk_all("dying");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.x", int'(frog_x), 304);
    chk("mrst.y", int'(frog_y), 440);
    chk("mrst.lives", int'(lives), 3);
    chk("mrst.score", int'(score), 0);
    chk("mrst.state", int'(game_state), 0);
    rst = 1'b0;
    model_reset();

    // Random play against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin press(int'($urandom_range(0, 3))); tick(); end
        3: begin press(int'($urandom_range(0, 3))); press(int'($urandom_range(0, 3))); tick(); end
        4: press(4);
        5: begin hit_pulse(); tick(); end
        6: for (int i = 0; i < 61; i++) tick();
        default: begin press(3); tick(); end
      endcase
      chk_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
